// File: rtl/universal_reg_if.sv
// Control, data and status signals of the universal shift/load register.
// Clock and reset stay outside the bundle.
interface universal_reg_if #(
  parameter int WIDTH = 8
) ();
  logic             CLR;
  logic             PRE;
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SIN_R;
  logic             SIN_L;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] _Q;
  logic             SOUT;
  logic             CONFLICT;

  modport master (
    output CLR, PRE, EN, MODE, D, SIN_R, SIN_L,
    input  Q, _Q, SOUT, CONFLICT
  );

  modport slave (
    input  CLR, PRE, EN, MODE, D, SIN_R, SIN_L,
    output Q, _Q, SOUT, CONFLICT
  );
endinterface

// File: rtl/universal_reg.sv
// Universal register: hold, shift right/left (serial or rotate), parallel load,
// active-low clear/preset, registered complement output and sticky CLR/PRE conflict flag.
module universal_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               ROTATE  = 1'b0
) (
  input  logic           CLK,
  input  logic           RST,
  universal_reg_if.slave bus
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q;
  logic             sout_q, sout_d;
  logic             conflict_q, conflict_d;
  logic             fill_r, fill_l;

  // Rotation recirculates the end bit instead of taking the serial input.
  assign fill_r = ROTATE ? q_q[0]       : bus.SIN_R;
  assign fill_l = ROTATE ? q_q[WIDTH-1] : bus.SIN_L;

  always_comb begin
    q_d        = q_q;
    sout_d     = sout_q;
    conflict_d = conflict_q;
    if (!bus.CLR && !bus.PRE) begin
      conflict_d = 1'b1;
    end else if (!bus.CLR) begin
      q_d = '0;
    end else if (!bus.PRE) begin
      q_d = '1;
    end else if (bus.EN) begin
      unique case (bus.MODE)
        MODE_HOLD: q_d = q_q;
        MODE_SHR: begin
          q_d    = {fill_r, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], fill_l};
          sout_d = q_q[WIDTH-1];
        end
        MODE_LOAD: q_d = bus.D;
        default:   q_d = q_q;
      endcase
    end
  end

  // Complement is registered from the same next-state so it never lags Q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q        <= RST_VAL;
      qn_q       <= ~RST_VAL;
      sout_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qn_q       <= ~q_d;
      sout_q     <= sout_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus._Q       = qn_q;
  assign bus.SOUT     = sout_q;
  assign bus.CONFLICT = conflict_q;

endmodule

// File: tb/tb_universal_reg.sv
// Directed bench for universal_reg: shift-mode instance and a rotate instance
// with a non-zero reset value share one stimulus.
module tb_universal_reg;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b1;
  logic       pre = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d = 8'h00;
  logic       sinr = 1'b0;
  logic       sinl = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  universal_reg_if #(.WIDTH(8)) a ();
  universal_reg_if #(.WIDTH(8)) b ();

  assign a.CLR = clr;  assign b.CLR = clr;
  assign a.PRE = pre;  assign b.PRE = pre;
  assign a.EN = en;    assign b.EN = en;
  assign a.MODE = mode; assign b.MODE = mode;
  assign a.D = d;      assign b.D = d;
  assign a.SIN_R = sinr; assign b.SIN_R = sinr;
  assign a.SIN_L = sinl; assign b.SIN_L = sinl;

  universal_reg #(.WIDTH(8), .RST_VAL(8'h00), .ROTATE(1'b0)) u_shift (
    .CLK(CLK), .RST(rst), .bus(a.slave)
  );

  universal_reg #(.WIDTH(8), .RST_VAL(8'h5A), .ROTATE(1'b1)) u_rot (
    .CLK(CLK), .RST(rst), .bus(b.slave)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] q, input logic sout, input logic cf);
    check({tag, ".Q"}, a.Q, q);
    check({tag, "._Q"}, a._Q, ~q);
    check({tag, ".SOUT"}, {7'd0, a.SOUT}, {7'd0, sout});
    check({tag, ".CONFLICT"}, {7'd0, a.CONFLICT}, {7'd0, cf});
  endtask

  initial begin
    // Reset beats clear and a pending load
    rst = 1'b1; clr = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hFF;
    tick();
    check_a("reset", 8'h00, 1'b0, 1'b0);
    check("reset.rot.Q", b.Q, 8'h5A);
    check("reset.rot._Q", b._Q, 8'hA5);

    rst = 1'b0; clr = 1'b1; d = 8'hA5;
    tick();
    check_a("load_a5", 8'hA5, 1'b0, 1'b0);

    mode = 2'b01; sinr = 1'b1;
    tick();
    check_a("shr", 8'hD2, 1'b1, 1'b0);

    mode = 2'b10; sinl = 1'b0;
    tick();
    check_a("shl", 8'hA4, 1'b1, 1'b0);

    // Hold with EN low while a shift mode is selected
    en = 1'b0; mode = 2'b01; sinr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("hold_en0", 8'hA4, 1'b1, 1'b0);
    end

    en = 1'b1; mode = 2'b00;
    tick();
    check_a("hold_mode0", 8'hA4, 1'b1, 1'b0);

    // RST pulse between edges has no effect
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    check_a("rst_glitch", 8'hA4, 1'b1, 1'b0);

    mode = 2'b11; d = 8'h81;
    tick();
    check("rot_load.Q", b.Q, 8'h81);

    mode = 2'b10; sinl = 1'b0;
    tick();
    check("rot_shl1.Q", b.Q, 8'h03);
    check("rot_shl1.SOUT", {7'd0, b.SOUT}, 8'h01);
    check_a("shl_nowrap1", 8'h02, 1'b1, 1'b0);
    tick();
    check("rot_shl2.Q", b.Q, 8'h06);
    check("rot_shl2._Q", b._Q, 8'hF9);
    check("rot_shl2.SOUT", {7'd0, b.SOUT}, 8'h00);
    check_a("shl_nowrap2", 8'h04, 1'b0, 1'b0);

    mode = 2'b11; d = 8'h01;
    tick();
    mode = 2'b01; sinr = 1'b0;
    tick();
    check("rot_shr.Q", b.Q, 8'h80);
    check("rot_shr.SOUT", {7'd0, b.SOUT}, 8'h01);
    check_a("shr_lsb_out", 8'h00, 1'b1, 1'b0);

    mode = 2'b11; d = 8'h3C;
    tick();
    check_a("load_3c", 8'h3C, 1'b1, 1'b0);

    // Preset overrides a parallel load
    d = 8'h00; pre = 1'b0;
    tick();
    check_a("preset", 8'hFF, 1'b1, 1'b0);

    clr = 1'b0; pre = 1'b0;
    tick();
    check_a("conflict", 8'hFF, 1'b1, 1'b1);

    clr = 1'b0; pre = 1'b1; d = 8'hAA;
    tick();
    check_a("clear", 8'h00, 1'b1, 1'b1);

    clr = 1'b1; pre = 1'b1; d = 8'h55;
    tick();
    check_a("sticky_load", 8'h55, 1'b1, 1'b1);

    mode = 2'b10; sinl = 1'b1;
    tick();
    check_a("sticky_shl", 8'hAB, 1'b0, 1'b1);

    // Reset during a fresh conflict still wins
    rst = 1'b1; clr = 1'b0; pre = 1'b0;
    tick();
    check_a("rst_conflict", 8'h00, 1'b0, 1'b0);
    check("rst_conflict.rot.Q", b.Q, 8'h5A);

    rst = 1'b0; clr = 1'b1; pre = 1'b1; mode = 2'b11; d = 8'h55;
    tick();
    check_a("post_rst_load", 8'h55, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 SHALL expose parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 SHALL expose parameter RST_VAL, default 0, meaning the WIDTH-bit value Q takes on reset.
REQ-003 SHALL expose parameter ROTATE, default 0, meaning 1 = shift modes wrap the end bit and ignore the serial inputs.
REQ-004 SHALL have port CLK, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit, meaning synchronous active-high reset.
REQ-006 SHALL have port CLR, input, 1 bit, meaning synchronous active-low clear of Q to all zeros.
REQ-007 SHALL have port PRE, input, 1 bit, meaning synchronous active-low preset of Q to all ones.
REQ-008 SHALL have port EN, input, 1 bit, meaning 1 enables the MODE operation, 0 holds.
REQ-009 SHALL have port MODE, input, 2 bits, meaning 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-010 SHALL have port D, input, WIDTH bits, meaning parallel load data.
REQ-011 SHALL have port SIN_R, input, 1 bit, meaning serial input entering the MSB on shift right.
REQ-012 SHALL have port SIN_L, input, 1 bit, meaning serial input entering the LSB on shift left.
REQ-013 SHALL have port Q, output, WIDTH bits, meaning registered state.
REQ-014 SHALL have port _Q, output, WIDTH bits, meaning bitwise complement of Q, registered alongside Q.
REQ-015 SHALL have port SOUT, output, 1 bit, meaning the bit shifted out on the last shift, registered.
REQ-016 SHALL have port CONFLICT, output, 1 bit, meaning sticky flag: CLR and PRE were asserted together.

Function
REQ-017 SHALL evaluate controls on each rising CLK edge in the priority RST > (CLR=0 and PRE=0) > CLR=0 > PRE=0 > EN/MODE.
REQ-018 SHALL, when CLR=0 and PRE=0 together, hold Q, _Q and SOUT unchanged and set CONFLICT to 1 on that edge.
REQ-019 SHALL, when only CLR=0, load Q=0 and _Q=all ones regardless of EN.
REQ-020 SHALL, when only PRE=0, load Q=all ones and _Q=0 regardless of EN.
REQ-021 SHALL hold Q when EN=0 or MODE=00.
REQ-022 SHALL, on shift right, load Q <= {SIN_R, Q[WIDTH-1:1]} and SOUT <= Q[0], or with ROTATE=1, Q <= {Q[0], Q[WIDTH-1:1]}.
REQ-023 SHALL, on shift left, load Q <= {Q[WIDTH-2:0], SIN_L} and SOUT <= Q[WIDTH-1], or with ROTATE=1, Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
REQ-024 SHALL, on parallel load, load Q <= D.
REQ-025 SHALL keep SOUT unchanged on every edge that is not a shift.
REQ-026 SHALL keep _Q equal to ~Q at every clock edge boundary, with no cycle of skew.
REQ-027 SHALL keep a raised CONFLICT high until RST, with normal operation continuing after the conflict clears.
REQ-028 SHALL give every update a latency of one cycle, with Q visible the cycle after the edge.
REQ-029 SHALL contain no combinational path from any input to any output.

Reset
REQ-030 SHALL, when RST=1 on an edge, force Q=RST_VAL, _Q=~RST_VAL, SOUT=0 and CONFLICT=0, overriding all other inputs.
REQ-031 SHALL ignore RST between edges, with no asynchronous effect.
REQ-032 SHALL let RST asserted mid-sequence, including during a CLR/PRE conflict, take effect on that same edge.

Verification (WIDTH=8, RST_VAL=0, ROTATE=0 unless stated)
REQ-033 SHALL cover reset: RST=1 with CLR=0 and D=FF for one edge -> Q=00, _Q=FF, SOUT=0, CONFLICT=0.
REQ-034 SHALL cover load/shift: load D=A5, then shift right with SIN_R=1 -> Q=D2, SOUT=1; then shift left with SIN_L=0 -> Q=A4, SOUT=1.
REQ-035 SHALL cover rotate: ROTATE=1, load 81, shift left twice -> Q=03 then Q=06, with SOUT=1 then 0.
REQ-036 SHALL cover priority: Q=3C, EN=1, MODE=11, D=00, PRE=0 -> Q=FF; then CLR=0 and PRE=0 -> Q stays FF and CONFLICT=1.
REQ-037 SHALL cover sticky flag: after CONFLICT=1 with CLR=PRE=1, load 55 -> Q=55 with CONFLICT still 1; then RST -> CONFLICT=0.
REQ-038 SHALL cover hold: EN=0 with MODE=01 for 3 edges -> Q and SOUT unchanged, and _Q==~Q checked every cycle.
